memory_access_ctrl: RTL and testbench
=====================================

Name: memory_access_ctrl

Overview:
- Bus-master (initiator) side of the synchronous RAM port used by the Mini SRC datapath. Owns the MAR/MDR view of a memory transaction.
- Accepts a single load or store request from the control unit, latches address and write data, and drives the RAM's address, read, write and data-in pins for exactly one strobe cycle.
- For loads, it captures the RAM's registered output into the MDR and returns a one-cycle done pulse.
- Sits between control_unit/datapath and memory_ram.

Parameters:
- ADDR_W, 9, RAM word-address width (512 words).
- DATA_W, 32, data word width.
- WAIT_CYCLES, 0, extra idle cycles inserted between strobe and capture/done (0..15), for slower memory models.

Ports:
- clk  in  1  system clock, all state on rising edge.
- clear  in  1  asynchronous, active-high reset.
- req  in  1  request valid; sampled only in IDLE.
- we  in  1  1 = store, 0 = load; sampled with req.
- addr  in  ADDR_W  word address; sampled with req.
- wdata  in  DATA_W  store data; sampled with req.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on transaction completion.
- rdata  out  DATA_W  MDR contents; holds the last load result.
- mem_address  out  ADDR_W  to RAM address_in (registered MAR).
- mem_read  out  1  to RAM read.
- mem_write  out  1  to RAM write.
- mem_wdata  out  DATA_W  to RAM data_input (registered).
- mem_rdata  in  DATA_W  from RAM data_output; X except in the cycle after a read strobe.

Behaviour:
- Reset (clear=1, asynchronous): state=IDLE. busy=0, done=0, mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, rdata=0, wait counter=0.
- Reset mid-transaction aborts it. No done pulse is issued. A strobe in flight is deasserted immediately.
- States: IDLE, SETUP, STROBE, WAIT, CAPTURE.
- IDLE:
  - On req=1, latch addr into MAR (mem_address), wdata into mem_wdata, and we into an internal op flag. Go to SETUP.
  - If req=0, stay in IDLE with all strobes at 0.
- SETUP: address is stable for one full cycle so the RAM's address latch settles. Strobes stay 0. Go to STROBE.
- STROBE: exactly one cycle.
  - Assert mem_write=op, mem_read=!op. Never assert both.
  - The RAM acts on the rising edge ending this cycle.
  - If WAIT_CYCLES=0, go to CAPTURE; otherwise load the counter with WAIT_CYCLES and go to WAIT.
- WAIT: strobes at 0. Decrement the counter each cycle; go to CAPTURE when the counter reaches 1.
  - WAIT is reachable only with WAIT_CYCLES≥1 and lasts exactly WAIT_CYCLES cycles.
- CAPTURE:
  - Load: rdata <= mem_rdata on the edge ending CAPTURE (RAM output is valid during CAPTURE when WAIT_CYCLES=0).
  - Store: rdata is unchanged.
  - done=1 for this cycle only. Return to IDLE.
- WAIT_CYCLES>0 caveat: the RAM drives X once read deasserts. The load value is therefore latched into an internal hold register on the edge ending STROBE+1 and transferred to rdata in CAPTURE.
- Latency: req sampled at edge 0 → done high in cycle 3+WAIT_CYCLES → rdata valid from cycle 4+WAIT_CYCLES. Throughput is one transaction per 4+WAIT_CYCLES cycles.
- req while busy=1 is ignored, not queued. A request is re-sampled only in IDLE.
- mem_address and mem_wdata hold their values after completion until the next accepted request.
- Address arithmetic: none. Out-of-range addresses are impossible by width.

Decomposition:
- Shared package mini_src_mem_pkg: ADDR_W/DATA_W constants, state encoding localparams (IDLE=0 … CAPTURE=4), and an op encoding constant (OP_LOAD=0, OP_STORE=1).
- One natural sub-module: mem_wait_counter (loadable down-counter with zero flag), used for the WAIT state.

Test Plan:
- Reset then idle: clear pulsed mid-cycle → all outputs 0 asynchronously; with req=0 for 10 cycles, mem_read and mem_write never assert.
- Store/load round-trip, WAIT_CYCLES=0, against memory_ram:
  - Store 0xDEADBEEF to 0x05 → mem_write high exactly one cycle in cycle 2, done in cycle 3.
  - Then load 0x05 → rdata=0xDEADBEEF from cycle 4, mem_read high exactly one cycle.
- Busy rejection: issue a load at 0x10, then hold req=1 with addr=0x1FF during busy → only one transaction occurs. A second transaction starts only once the controller is back in IDLE.
- Boundary addresses: store/load at 0x000 and 0x1FF with 0xFFFFFFFF and 0x00000000 → exact readback, no aliasing.
- WAIT_CYCLES=3: load from a preloaded address → done in cycle 6, rdata correct despite RAM driving X during WAIT; strobe width stays 1 cycle.
- Reset mid-op: assert clear during STROBE of a store → mem_write drops immediately, no done; a subsequent load of the same address returns the pre-store value or the new value consistently with whether the RAM edge occurred.

Source files
------------

// File: rtl/memory_access_ctrl_pkg.sv
// Shared constants and encodings for the Mini SRC memory port controller.
package mini_src_mem_pkg;

  localparam int MEM_ADDR_W = 9;
  localparam int MEM_DATA_W = 32;
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_WAIT    = 3'd3,
    ST_CAPTURE = 3'd4
  } mem_state_e;

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

endpackage

// File: rtl/memory_access_ctrl_wait_counter.sv
// Loadable down-counter that times the extra idle cycles after a strobe.
module mem_wait_counter
  import mini_src_mem_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  clear_i,
  input  logic                  load_i,
  input  logic [WAIT_CNT_W-1:0] load_val_i,
  input  logic                  dec_i,
  output logic [WAIT_CNT_W-1:0] count_o,
  output logic                  zero_o
);

  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

  // Load has priority; decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge clear_i) begin
    if (clear_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/memory_access_ctrl.sv
// Initiator side of the Mini SRC RAM port: one load or store per request,
// single-cycle strobe, optional wait cycles before capture.
//
// state   | meaning
// IDLE    | waiting for req; MAR/MDR hold their last values
// SETUP   | address stable one cycle for the RAM address latch
// STROBE  | one-cycle read or write strobe
// WAIT    | WAIT_CYCLES idle cycles for slower memory models
// CAPTURE | done pulse; load data written into rdata
module memory_access_ctrl
  import mini_src_mem_pkg::*;
#(
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int DATA_W      = MEM_DATA_W,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES);

  mem_state_e        state_q, state_d;
  logic              op_q, op_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              rd_pend_q, rd_pend_d;

  logic                  cnt_load, cnt_dec, cnt_zero;
  logic [WAIT_CNT_W-1:0] cnt_count;

  mem_wait_counter u_wait_cnt (
    .clk_i      (clk),
    .clear_i    (clear),
    .load_i     (cnt_load),
    .load_val_i (WAIT_LOAD),
    .dec_i      (cnt_dec),
    .count_o    (cnt_count),
    .zero_o     (cnt_zero)
  );

  // Next-state, datapath updates and strobe/status outputs.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    mar_d     = mar_q;
    wd_d      = wd_q;
    rdata_d   = rdata_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    done      = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    busy      = (state_q != ST_IDLE);
    // The RAM output is only valid the cycle after a read strobe, so with
    // wait cycles the value is parked here until CAPTURE.
    rd_pend_d = (state_q == ST_STROBE) && (op_q == OP_LOAD);
    hold_d    = rd_pend_q ? mem_rdata : hold_q;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          mar_d   = addr;
          wd_d    = wdata;
          op_d    = we;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_STROBE;
      end
      ST_STROBE: begin
        mem_write = (op_q == OP_STORE);
        mem_read  = (op_q == OP_LOAD);
        if (WAIT_CYCLES == 0) begin
          state_d = ST_CAPTURE;
        end else begin
          cnt_load = 1'b1;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // zero is a guard against a stuck counter; count==1 is the normal exit.
        if ((cnt_count == WAIT_CNT_W'(1)) || cnt_zero) begin
          state_d = ST_CAPTURE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_CAPTURE: begin
        done = 1'b1;
        if (op_q == OP_LOAD) begin
          rdata_d = (WAIT_CYCLES == 0) ? mem_rdata : hold_q;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; clear aborts any transaction in flight.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_LOAD;
      mar_q     <= '0;
      wd_q      <= '0;
      rdata_q   <= '0;
      hold_q    <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      mar_q     <= mar_d;
      wd_q      <= wd_d;
      rdata_q   <= rdata_d;
      hold_q    <= hold_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  assign rdata       = rdata_q;
  assign mem_address = mar_q;
  assign mem_wdata   = wd_q;

endmodule

// File: tb/tb_memory_access_ctrl.sv
// Bench for memory_access_ctrl: two instances (WAIT_CYCLES 0 and 3), each
// with its own synchronous RAM model that drives garbage when not read.
module tb_memory_access_ctrl;

  logic clk = 1'b0;
  logic clear = 1'b1;
  logic ram_init = 1'b1;

  logic [1:0]        req = '0, we = '0;
  logic [1:0][8:0]   addr = '0;
  logic [1:0][31:0]  wdata = '0;
  logic [1:0]        busy, done, mem_read, mem_write;
  logic [1:0][31:0]  rdata, mem_wdata, mem_rdata;
  logic [1:0][8:0]   mem_address;

  logic [31:0] ram [2][512];
  logic [31:0] sb_q [$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  memory_access_ctrl #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .clear(clear), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .busy(busy[0]), .done(done[0]), .rdata(rdata[0]),
    .mem_address(mem_address[0]), .mem_read(mem_read[0]),
    .mem_write(mem_write[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0])
  );

  memory_access_ctrl #(.WAIT_CYCLES(3)) dut1 (
    .clk(clk), .clear(clear), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .busy(busy[1]), .done(done[1]), .rdata(rdata[1]),
    .mem_address(mem_address[1]), .mem_read(mem_read[1]),
    .mem_write(mem_write[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1])
  );

  // RAM models: registered output valid only the cycle after a read strobe.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (ram_init) begin
        for (int i = 0; i < 512; i++) ram[g][i] <= 32'hC0DE_0000 | 32'(i);
      end else if (mem_write[g]) begin
        ram[g][mem_address[g]] <= mem_wdata[g];
      end
      if (mem_read[g]) mem_rdata[g] <= ram[g][mem_address[g]];
      else             mem_rdata[g] <= 32'hBAD0_BAD0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a negedge with the selected DUT idle. Checks every cycle of
  // the transaction; with hog set, req stays high pointing at 0x1FF.
  task automatic run_txn(input int s, input logic w, input logic [8:0] a,
                         input logic [31:0] d, input bit hog, input logic [31:0] exp_rd);
    int lat;
    logic [31:0] exp;
    lat = (s == 1) ? 6 : 3;
    req[s] = 1'b1; we[s] = w; addr[s] = a; wdata[s] = d;
    sb_q.push_back(exp_rd);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (hog) begin
        req[s] = 1'b1; we[s] = 1'b1; addr[s] = 9'h1FF; wdata[s] = 32'h5555_AAAA;
      end else begin
        req[s] = 1'b0;
      end
      chk("busy_in_txn", 32'(busy[s]), 32'd1);
      chk("mar_held", 32'(mem_address[s]), 32'(a));
      chk("rd_strobe", 32'(mem_read[s]), 32'((c == 2) && !w));
      chk("wr_strobe", 32'(mem_write[s]), 32'((c == 2) && w));
      chk("done_timing", 32'(done[s]), 32'(c == lat));
    end
    @(negedge clk);
    req[s] = 1'b0;
    chk("busy_after", 32'(busy[s]), 32'd0);
    chk("done_pulse_end", 32'(done[s]), 32'd0);
    exp = sb_q.pop_front();
    chk("rdata", rdata[s], exp);
    if (w) chk("mem_wdata_hold", mem_wdata[s], d);
  endtask

  typedef struct {
    logic        w;
    logic [8:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [11];

  initial begin
    vecs[0]  = '{1'b1, 9'h005, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[1]  = '{1'b0, 9'h005, 32'h0,         32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 9'h000, 32'hFFFF_FFFF, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b1, 9'h1FF, 32'h0000_0000, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b0, 9'h000, 32'h0,         32'hFFFF_FFFF};
    vecs[5]  = '{1'b0, 9'h1FF, 32'h0,         32'h0000_0000};
    vecs[6]  = '{1'b1, 9'h000, 32'h0000_0000, 32'h0000_0000};
    vecs[7]  = '{1'b1, 9'h1FF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[8]  = '{1'b0, 9'h1FF, 32'h0,         32'hFFFF_FFFF};
    vecs[9]  = '{1'b0, 9'h000, 32'h0,         32'h0000_0000};
    vecs[10] = '{1'b0, 9'h005, 32'h0,         32'hDEAD_BEEF};

    repeat (2) @(posedge clk);
    @(negedge clk);
    ram_init = 1'b0;
    for (int s = 0; s < 2; s++) begin
      chk("rst_busy", 32'(busy[s]), 32'd0);
      chk("rst_done", 32'(done[s]), 32'd0);
      chk("rst_strobes", 32'({mem_read[s], mem_write[s]}), 32'd0);
      chk("rst_addr", 32'(mem_address[s]), 32'd0);
      chk("rst_wdata", mem_wdata[s], 32'd0);
      chk("rst_rdata", rdata[s], 32'd0);
    end
    clear = 1'b0;

    repeat (10) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        chk("idle_strobes", 32'({mem_read[s], mem_write[s]}), 32'd0);
        chk("idle_busy", 32'(busy[s]), 32'd0);
      end
    end

    for (int i = 0; i < 11; i++) begin
      run_txn(0, vecs[i].w, vecs[i].a, vecs[i].d, 1'b0, vecs[i].exp);
    end

    // Busy rejection: the hogged store to 0x1FF must never happen.
    run_txn(0, 1'b0, 9'h010, 32'h0, 1'b1, 32'hC0DE_0010);
    run_txn(0, 1'b0, 9'h1FF, 32'h0, 1'b0, 32'hFFFF_FFFF);

    // Wait-cycle instance: RAM output is garbage during WAIT.
    run_txn(1, 1'b0, 9'h033, 32'h0, 1'b0, 32'hC0DE_0033);
    run_txn(1, 1'b1, 9'h044, 32'h1234_5678, 1'b0, 32'hC0DE_0033);
    run_txn(1, 1'b0, 9'h044, 32'h0, 1'b0, 32'h1234_5678);

    // Reset during the STROBE of a store to 0x020.
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 9'h020; wdata[0] = 32'h0BAD_F00D;
    @(negedge clk);
    req[0] = 1'b0;
    @(negedge clk);
    chk("pre_clear_wr_strobe", 32'(mem_write[0]), 32'd1);
    #1 clear = 1'b1;
    #1;
    chk("clear_wr_drop", 32'(mem_write[0]), 32'd0);
    chk("clear_busy", 32'(busy[0]), 32'd0);
    chk("clear_addr", 32'(mem_address[0]), 32'd0);
    chk("clear_wdata", mem_wdata[0], 32'd0);
    chk("clear_rdata", rdata[0], 32'd0);
    chk("clear_done", 32'(done[0]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("no_done_after_abort", 32'(done[0]), 32'd0);
    end
    // The write strobe was gone before the RAM edge, so the old value stays.
    run_txn(0, 1'b0, 9'h020, 32'h0, 1'b0, 32'hC0DE_0020);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
